sevseg_mux_scan: RTL and testbench

Parametrised multiplexed seven-segment display driver for Tiny Tapeout designs. It time-multiplexes NUM_DIGITS nibble digits onto one shared 7-bit segment bus with one-hot digit enables. It adds a programmable refresh rate, optional hex decoding, leading-zero blanking and a tear-free value-load handshake. It sits between the design's value-producing logic and the `uo_out`/`uio_out` pins.

---
 rtl/sevseg_mux_scan.sv | 140 ++++++++++++++
 tb/tb_sevseg_mux_scan.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevseg_mux_scan.sv
// Multiplexed seven-segment scanner: a prescaled digit index, a tear-free
// load buffer that commits on frame boundaries, and per-digit decode lanes.

module sevseg_mux_scan_lane (
  input  logic [3:0] nib_i,
  input  logic       hex_en_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = 7'b0000000;
    if (!blank_i) begin
      unique case (nib_i)
        4'h0: seg_o = 7'b0111111;
        4'h1: seg_o = 7'b0000110;
        4'h2: seg_o = 7'b1011011;
        4'h3: seg_o = 7'b1001111;
        4'h4: seg_o = 7'b1100110;
        4'h5: seg_o = 7'b1101101;
        4'h6: seg_o = 7'b1111101;
        4'h7: seg_o = 7'b0000111;
        4'h8: seg_o = 7'b1111111;
        4'h9: seg_o = 7'b1101111;
        4'hA: seg_o = hex_en_i ? 7'b1110111 : 7'b0000000;
        4'hB: seg_o = hex_en_i ? 7'b1111100 : 7'b0000000;
        4'hC: seg_o = hex_en_i ? 7'b0111001 : 7'b0000000;
        4'hD: seg_o = hex_en_i ? 7'b1011110 : 7'b0000000;
        4'hE: seg_o = hex_en_i ? 7'b1111001 : 7'b0000000;
        4'hF: seg_o = hex_en_i ? 7'b1110001 : 7'b0000000;
        default: seg_o = 7'b0000000;
      endcase
    end
  end
endmodule

module sevseg_mux_scan #(
  parameter int NUM_DIGITS = 2,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DIV_WIDTH-1:0]    div_limit,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic                    blank_lz,
  input  logic                    hex_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_tick
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW    = 4 * NUM_DIGITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VW-1:0]         disp_q, disp_d;
  logic [VW-1:0]         pend_q, pend_d;
  logic                  pend_full_q, pend_full_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
  logic                  frame_tick_q;

  logic tick, boundary, xfer;

  // zero_above[k]: every nibble at positions k..NUM_DIGITS-1 is zero
  logic [NUM_DIGITS:0]        zero_above;
  logic [NUM_DIGITS-1:0][6:0] lane_seg;

  assign zero_above[NUM_DIGITS] = 1'b1;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lane
    logic [3:0] nib;
    logic       blank;
    assign nib           = disp_q[4*k +: 4];
    assign zero_above[k] = (nib == 4'd0) & zero_above[k+1];
    assign blank         = blank_lz & (k != 0) & zero_above[k];
    sevseg_mux_scan_lane u_lane (
      .nib_i    (nib),
      .hex_en_i (hex_en),
      .blank_i  (blank),
      .seg_o    (lane_seg[k])
    );
  end

  assign tick       = (cnt_q >= div_limit);
  assign boundary   = tick & (idx_q == LAST_IDX);
  assign load_ready = ~pend_full_q;
  assign xfer       = load_valid & load_ready;

  always_comb begin
    cnt_d       = tick ? '0 : cnt_q + 1'b1;
    idx_d       = idx_q;
    disp_d      = disp_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    if (tick) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    // A transfer landing on the boundary bypasses the buffer entirely.
    if (boundary) begin
      if (pend_full_q) begin
        disp_d      = pend_q;
        pend_full_d = 1'b0;
      end else if (xfer) begin
        disp_d = value_in;
      end
    end else if (xfer) begin
      pend_d      = value_in;
      pend_full_d = 1'b1;
    end
    seg_d     = lane_seg[idx_q];
    dig_sel_d = NUM_DIGITS'(1) << idx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      seg_q        <= '0;
      dig_sel_q    <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      seg_q        <= seg_d;
      dig_sel_q    <= dig_sel_d;
      frame_tick_q <= boundary;
    end
  end

  assign seg        = seg_q;
  assign dig_sel    = dig_sel_q;
  assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_sevseg_mux_scan.sv
// Bench for sevseg_mux_scan: directed scenarios plus randomized traffic
// checked against an integer-level model of the display behaviour.
module tb_sevseg_mux_scan;
  localparam int ND = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] div_limit;
  logic [7:0]  value_in;
  logic        load_valid, load_ready, blank_lz, hex_en;
  logic [6:0]  seg;
  logic [1:0]  dig_sel;
  logic        frame_tick;

  int total = 0;
  int bad   = 0;

  sevseg_mux_scan #(.NUM_DIGITS(ND), .DIV_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .div_limit(div_limit), .value_in(value_in),
    .load_valid(load_valid), .load_ready(load_ready), .blank_lz(blank_lz),
    .hex_en(hex_en), .seg(seg), .dig_sel(dig_sel), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  logic [6:0] PAT [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                           7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                           7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                           7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

  function automatic logic [6:0] pat(int unsigned v, int unsigned d, bit bl, bit hx);
    int unsigned nib;
    nib = (v >> (4*d)) & 15;
    if (bl && d > 0 && (v >> (4*d)) == 0) return 7'b0;
    if (nib > 9 && !hx) return 7'b0;
    return PAT[nib];
  endfunction

  // Reference model: digit position, committed/pending values as integers.
  int unsigned m_cnt, m_idx, m_disp, m_pend;
  bit          m_full, m_ft;
  logic [6:0]  m_seg;
  logic [1:0]  m_dig;
  bit m_tick, m_bnd, m_xfer;
  assign m_tick = (m_cnt >= 32'(div_limit));
  assign m_bnd  = m_tick && (m_idx == ND - 1);
  assign m_xfer = load_valid && !m_full;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_idx <= 0; m_disp <= 0; m_pend <= 0; m_full <= 0;
      m_seg <= '0; m_dig <= '0; m_ft <= 0;
    end else begin
      m_seg <= pat(m_disp, m_idx, blank_lz, hex_en);
      m_dig <= 2'(1 << m_idx);
      m_ft  <= m_bnd;
      if (m_bnd) begin
        if (m_full) begin m_disp <= m_pend; m_full <= 0; end
        else if (m_xfer) m_disp <= 32'(value_in);
      end else if (m_xfer) begin
        m_pend <= 32'(value_in); m_full <= 1;
      end
      m_cnt <= m_tick ? 0 : m_cnt + 1;
      if (m_tick) m_idx <= (m_idx + 1) % ND;
    end
  end

  task automatic do_load(input logic [7:0] v);
    int n = 0;
    load_valid = 1'b1; value_in = v;
    while (load_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    total++;
    if (n >= 100) begin bad++; $display("FAIL load_timeout: ready=%b exp 1", load_ready); end
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic wait_ft();
    int n = 0;
    while (frame_tick !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    total++;
    if (n >= 100) begin bad++; $display("FAIL frame_timeout: frame_tick=%b exp 1", frame_tick); end
  endtask

  task automatic wait_commit();
    wait_ft();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; div_limit = 16'd3; value_in = '0; load_valid = 0; blank_lz = 0; hex_en = 0;
    #2 rst_n = 1'b0;
    #2;
    total++; if ({seg, dig_sel, frame_tick} !== 10'b0) begin bad++;
      $display("FAIL reset_outs: got %b exp 0", {seg, dig_sel, frame_tick}); end
    total++; if (load_ready !== 1'b1) begin bad++;
      $display("FAIL reset_ready: got %b exp 1", load_ready); end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    total++; if (dig_sel !== 2'b01 || seg !== 7'b0111111) begin bad++;
      $display("FAIL first_cycle: dig=%b seg=%b exp 01 0111111", dig_sel, seg); end
  endtask

  task automatic test_basic_scan();
    int last_chg = -1, last_ft = -1;
    logic [1:0] prev;
    logic [6:0] exp;
    do_load(8'h23);
    wait_commit();
    prev = dig_sel;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (dig_sel !== prev) begin
        if (last_chg >= 0) begin total++; if (c - last_chg != 4) begin bad++;
          $display("FAIL dwell: got %0d exp 4", c - last_chg); end end
        last_chg = c;
      end
      prev = dig_sel;
      if (frame_tick === 1'b1) begin
        if (last_ft >= 0) begin total++; if (c - last_ft != 8) begin bad++;
          $display("FAIL frame_period: got %0d exp 8", c - last_ft); end end
        last_ft = c;
      end
      exp = (dig_sel == 2'b01) ? 7'b1001111 : 7'b1011011;
      total++;
      if ((dig_sel !== 2'b01 && dig_sel !== 2'b10) || seg !== exp) begin bad++;
        $display("FAIL basic_seg: dig=%b seg=%b exp %b", dig_sel, seg, exp); end
    end
  endtask

  task automatic test_blanking();
    int seen = 0;
    blank_lz = 1; hex_en = 0;
    do_load(8'h05);
    wait_commit();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      total++;
      if (dig_sel == 2'b10) begin
        seen++;
        if (seg !== 7'b0) begin bad++; $display("FAIL blank_d1: got %b exp 0000000", seg); end
      end else if (seg !== 7'b1101101) begin bad++;
        $display("FAIL blank_d0: got %b exp 1101101", seg); end
    end
    total++; if (seen == 0) begin bad++; $display("FAIL blank_digsel: got 0 exp >0 cycles of 10"); end
    blank_lz = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (dig_sel == 2'b10) begin total++; if (seg !== 7'b0111111) begin bad++;
        $display("FAIL noblank_d1: got %b exp 0111111", seg); end end
    end
    blank_lz = 1;
    do_load(8'h00);
    wait_commit();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      total++;
      if (dig_sel == 2'b01 && seg !== 7'b0111111) begin bad++;
        $display("FAIL zero_d0: got %b exp 0111111", seg); end
      else if (dig_sel == 2'b10 && seg !== 7'b0) begin bad++;
        $display("FAIL zero_d1: got %b exp 0000000", seg); end
    end
  endtask

  task automatic test_hex();
    blank_lz = 0; hex_en = 1;
    do_load(8'h0A);
    wait_commit();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (dig_sel == 2'b01) begin total++; if (seg !== 7'b1110111) begin bad++;
        $display("FAIL hex_on: got %b exp 1110111", seg); end end
    end
    hex_en = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (dig_sel == 2'b01) begin total++; if (seg !== 7'b0) begin bad++;
        $display("FAIL hex_off: got %b exp 0000000", seg); end end
    end
  endtask

  task automatic test_handshake_mid();
    int n = 0;
    logic [6:0] old;
    hex_en = 1; blank_lz = 0;
    wait_ft();
    load_valid = 1; value_in = 8'h11;
    @(negedge clk);
    total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL mid_ready_fall: got %b exp 0", load_ready); end
    value_in = 8'h47;
    forever begin
      @(negedge clk); n++;
      old = (dig_sel == 2'b01) ? 7'b1110111 : 7'b0111111;
      total++; if (seg !== old) begin bad++; $display("FAIL mid_old_seg: got %b exp %b", seg, old); end
      if (frame_tick === 1'b1 || n > 30) break;
      total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL mid_ready_low: got %b exp 0", load_ready); end
    end
    total++; if (load_ready !== 1'b1 || frame_tick !== 1'b1) begin bad++;
      $display("FAIL mid_ready_rise: ready=%b ft=%b exp 1 1", load_ready, frame_tick); end
    @(negedge clk);
    load_valid = 0;
    total++; if (load_ready !== 1'b0 || dig_sel !== 2'b01 || seg !== 7'b0000110) begin bad++;
      $display("FAIL mid_commit: ready=%b dig=%b seg=%b exp 0 01 0000110", load_ready, dig_sel, seg); end
    wait_commit();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      old = (dig_sel == 2'b01) ? 7'b0000111 : 7'b1100110;
      total++; if (seg !== old) begin bad++; $display("FAIL mid_second: got %b exp %b", seg, old); end
    end
  endtask

  task automatic test_handshake_boundary();
    wait_ft();
    repeat (7) @(negedge clk);
    load_valid = 1; value_in = 8'h36;
    @(negedge clk);
    load_valid = 0;
    total++; if (load_ready !== 1'b1 || frame_tick !== 1'b1) begin bad++;
      $display("FAIL bnd_ready: ready=%b ft=%b exp 1 1", load_ready, frame_tick); end
    @(negedge clk);
    total++; if (dig_sel !== 2'b01 || seg !== 7'b1111101) begin bad++;
      $display("FAIL bnd_show: dig=%b seg=%b exp 01 1111101", dig_sel, seg); end
  endtask

  task automatic test_edges();
    logic [1:0] prev, d0;
    int stable = 1;
    div_limit = 16'd0;
    @(negedge clk); prev = dig_sel;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      if (c >= 2) begin total++; if (dig_sel === prev) begin bad++;
        $display("FAIL div0_toggle: got %b exp not %b", dig_sel, prev); end end
      prev = dig_sel;
    end
    div_limit = 16'd100;
    @(negedge clk); d0 = dig_sel;
    for (int c = 2; c <= 50; c++) begin @(negedge clk); if (dig_sel !== d0) stable = 0; end
    total++; if (stable != 1) begin bad++; $display("FAIL div100_stable: got %0d exp 1", stable); end
    div_limit = 16'd2;
    @(negedge clk);
    total++; if (dig_sel !== d0) begin bad++; $display("FAIL drop_hold: got %b exp %b", dig_sel, d0); end
    @(negedge clk);
    total++; if (dig_sel === d0) begin bad++; $display("FAIL drop_tick: got %b exp not %b", dig_sel, d0); end
    div_limit = 16'd3;
  endtask

  task automatic test_reset_mid();
    hex_en = 1; blank_lz = 0;
    wait_ft();
    load_valid = 1; value_in = 8'h99;
    @(negedge clk);
    load_valid = 0;
    total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL rm_pend: got %b exp 0", load_ready); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({seg, dig_sel, frame_tick, load_ready} !== 11'b1) begin bad++;
      $display("FAIL rm_async: got %b exp 00000000001", {seg, dig_sel, frame_tick, load_ready}); end
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++; if (seg !== 7'b0111111) begin bad++; $display("FAIL rm_discard: got %b exp 0111111", seg); end
    end
  endtask

  task automatic test_random();
    logic [10:0] exp;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      exp = {m_seg, m_dig, m_ft, ~m_full};
      total++;
      if ({seg, dig_sel, frame_tick, load_ready} !== exp) begin bad++;
        $display("FAIL rand_cyc%0d: got %b exp %b", c, {seg, dig_sel, frame_tick, load_ready}, exp); end
      if (!(load_valid && !load_ready)) begin
        load_valid = ($urandom % 3) == 0;
        value_in   = 8'($urandom);
      end
      if ($urandom % 40 == 0) div_limit = 16'($urandom % 6);
      if ($urandom % 20 == 0) begin blank_lz = 1'($urandom); hex_en = 1'($urandom); end
    end
    load_valid = 0;
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_blanking();
    test_hex();
    test_handshake_mid();
    test_handshake_boundary();
    test_edges();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
